// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
//   In IDLE it picks the next pending requester after the rotation pointer, latches that
//   requester's byte, and then pulses tx_start and the matching gnt bit for one cycle.
//   It holds ownership until the transmitter reports tx_done, then rotates priority.
//
// Ports
//   clock_out     oversampled baud clock, rising edge
//   nreset        asynchronous active-low reset
//   req_i         per-requester byte-pending flags (level)
//   data_in_i     requester i's byte at [i*BYTESIZES +: BYTESIZES]
//   gnt_o         one-hot, single-cycle accept pulse
//   tx_start_o    single-cycle transmitter launch pulse
//   tx_data_o     latched byte, stable from tx_start until back in IDLE
//   tx_busy_i     transmitter is inside a frame
//   tx_done_i     single-cycle end-of-stop-bit pulse
//   owner_o       index of current / last granted requester
//   timeout_err_o sticky watchdog flag (only with UART_ARB_TIMEOUT_EN)
//
// Build option
//   UART_ARB_TIMEOUT_EN  adds a watchdog that abandons a frame after TIMEOUT_CYCLES.

module uart_tx_arbiter #(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned BYTESIZES      = 8,
   parameter int unsigned OVERSAMPLING   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2 * OVERSAMPLING * (BYTESIZES + 2)
) (
   input  logic                      clock_out,
   input  logic                      nreset,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ*BYTESIZES-1:0] data_in_i,
   output logic [NREQ-1:0]           gnt_o,
   output logic                      tx_start_o,
   output logic [BYTESIZES-1:0]      tx_data_o,
   input  logic                      tx_busy_i,
   input  logic                      tx_done_i,
   output logic [$clog2(NREQ)-1:0]   owner_o
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                      timeout_err_o
`endif
);

   localparam int unsigned OwnerW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StWaitBusy,
      StWaitDone
   } state_e;

   state_e                state_q, state_d;
   logic [OwnerW-1:0]     ptr_q, ptr_d;
   logic [OwnerW-1:0]     owner_q, owner_d;
   logic [BYTESIZES-1:0]  data_q, data_d;
   logic [NREQ-1:0]       gnt_q, gnt_d;
   logic                  start_q, start_d;

   logic                  win_valid;
   logic [OwnerW-1:0]     win_idx;
   logic [OwnerW-1:0]     cand;
   logic [BYTESIZES-1:0]  byte_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_bytes
      assign byte_arr[g] = data_in_i[g*BYTESIZES +: BYTESIZES];
   end

   // Scan from ptr+1 upward, wrapping modulo NREQ (not modulo 2^OwnerW).
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = OwnerW'((32'(ptr_q) + 1 + k) % NREQ);
         if (!win_valid && req_i[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      data_d  = data_q;
      gnt_d   = '0;
      start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_valid && !tx_busy_i) begin
               owner_d        = win_idx;
               data_d         = byte_arr[win_idx];
               gnt_d[win_idx] = 1'b1;
               start_d        = 1'b1;
               state_d        = StLoad;
            end
         end
         StLoad: begin
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            // A done pulse before busy is seen still means the frame is over.
            if (tx_done_i) begin
               ptr_d   = owner_q;
               state_d = StIdle;
            end else if (tx_busy_i) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (tx_done_i) begin
               ptr_d   = owner_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef UART_ARB_TIMEOUT_EN
      // cnt_q is 0 in the first cycle after LOAD, so LOAD itself is elapsed cycle one and
      // the abort edge lands exactly TIMEOUT_CYCLES edges after LOAD began. tx_done wins.
      if ((state_q == StWaitBusy || state_q == StWaitDone) && !tx_done_i) begin
         if (cnt_q == CntW'(TIMEOUT_CYCLES - 2)) begin
            err_d   = 1'b1;
            ptr_d   = owner_q;
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clock_out or negedge nreset) begin
      if (!nreset) begin
         state_q <= StIdle;
         ptr_q   <= OwnerW'(NREQ - 1);
         owner_q <= '0;
         data_q  <= '0;
         gnt_q   <= '0;
         start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         start_q <= start_d;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign gnt_o      = gnt_q;
   assign tx_start_o = start_q;
   assign tx_data_o  = data_q;
   assign owner_o    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_err_o = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: scenario tasks with a rotation-order reference model and a
// simple transmitter model driven cycle by cycle from the main thread.

module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int BW   = 8;
   localparam int OS   = 16;
   localparam int TMO  = 2 * OS * (BW + 2);
   localparam int OW   = $clog2(NREQ);

   logic                 clock_out = 1'b0;
   logic                 nreset;
   logic [NREQ-1:0]      req_i;
   logic [NREQ*BW-1:0]   data_in_i;
   logic [NREQ-1:0]      gnt_o;
   logic                 tx_start_o;
   logic [BW-1:0]        tx_data_o;
   logic                 tx_busy_i;
   logic                 tx_done_i;
   logic [OW-1:0]        owner_o;
`ifdef UART_ARB_TIMEOUT_EN
   logic                 timeout_err_o;
`endif

   uart_tx_arbiter #(
      .NREQ          (NREQ),
      .BYTESIZES     (BW),
      .OVERSAMPLING  (OS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_out (clock_out),
      .nreset    (nreset),
      .req_i     (req_i),
      .data_in_i (data_in_i),
      .gnt_o     (gnt_o),
      .tx_start_o(tx_start_o),
      .tx_data_o (tx_data_o),
      .tx_busy_i (tx_busy_i),
      .tx_done_i (tx_done_i),
      .owner_o   (owner_o)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .timeout_err_o(timeout_err_o)
`endif
   );

   always #5 clock_out = ~clock_out;

   int total = 0;
   int bad   = 0;

   // Model state
   int              last;        // index that most recently completed a frame
   bit              auto_tx;     // transmitter model answers tx_start by itself
   int              frame_len;
   int              tx_cnt;
   bit              frame_open;
   int              exp_win;
   logic [NREQ-1:0] exp_gnt;

   // Observations from the most recent tick
   logic            o_start;
   logic [NREQ-1:0] o_gnt;
   logic [BW-1:0]   o_data;
   logic [OW-1:0]   o_owner;
   logic [NREQ-1:0] sel_req;
   logic [NREQ*BW-1:0] sel_data;

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int from_last);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (from_last + k) % NREQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic rand_data();
      for (int k = 0; k < NREQ; k++) data_in_i[k*BW +: BW] = BW'($urandom);
   endtask

   task automatic do_reset();
      nreset     = 1'b0;
      req_i      = '0;
      tx_busy_i  = 1'b0;
      tx_done_i  = 1'b0;
      frame_open = 1'b0;
      auto_tx    = 1'b0;
      last       = NREQ - 1;
      @(posedge clock_out);
      #1 nreset = 1'b1;
   endtask

   // One clock: capture what the DUT saw, sample outputs 1 time unit after the edge, and
   // advance the transmitter and rotation models.
   task automatic tick();
      sel_req  = req_i;
      sel_data = data_in_i;
      @(posedge clock_out);
      #1;
      o_start = tx_start_o;
      o_gnt   = gnt_o;
      o_data  = tx_data_o;
      o_owner = owner_o;
      if (tx_done_i) begin
         tx_done_i  = 1'b0;
         frame_open = 1'b0;
         last       = exp_win;
      end
      if (o_start) begin
         exp_win = rr_pick(sel_req, last);
         exp_gnt = '0;
         if (exp_win >= 0) exp_gnt[exp_win] = 1'b1;
         frame_open = 1'b1;
         if (auto_tx) begin
            tx_busy_i = 1'b1;
            tx_cnt    = frame_len;
         end
      end else if (auto_tx && frame_open && tx_busy_i) begin
         tx_cnt--;
         if (tx_cnt == 0) begin
            tx_busy_i = 1'b0;
            tx_done_i = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      nreset    = 1'b0;
      req_i     = '0;
      data_in_i = '0;
      tx_busy_i = 1'b0;
      tx_done_i = 1'b0;
      #3;
      total++;
      if (tx_start_o !== 1'b0) begin
         bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start_o);
      end
      total++;
      if (gnt_o !== '0) begin
         bad++; $display("FAIL reset_gnt: got %b want 0", gnt_o);
      end
      total++;
      if (tx_data_o !== '0) begin
         bad++; $display("FAIL reset_tx_data: got %h want 0", tx_data_o);
      end
      total++;
      if (owner_o !== '0) begin
         bad++; $display("FAIL reset_owner: got %0d want 0", owner_o);
      end
`ifdef UART_ARB_TIMEOUT_EN
      total++;
      if (timeout_err_o !== 1'b0) begin
         bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err_o);
      end
`endif
      @(posedge clock_out);
      #1 nreset = 1'b1;
      last       = NREQ - 1;
      frame_open = 1'b0;
   endtask

   task automatic test_single();
      int guard;
      do_reset();
      auto_tx   = 1'b1;
      frame_len = 20;
      rand_data();
      data_in_i[0 +: BW] = 8'hA5;
      req_i = 4'b0001;
      tick();
      total++;
      if (o_start !== 1'b1) begin
         bad++; $display("FAIL single_start: got %b want 1", o_start);
      end
      total++;
      if (o_gnt !== 4'b0001) begin
         bad++; $display("FAIL single_gnt: got %b want 0001", o_gnt);
      end
      total++;
      if (o_data !== 8'hA5) begin
         bad++; $display("FAIL single_data: got %h want a5", o_data);
      end
      total++;
      if (o_owner !== 2'd0) begin
         bad++; $display("FAIL single_owner: got %0d want 0", o_owner);
      end
      req_i = '0;
      tick();
      total++;
      if (o_start !== 1'b0 || o_gnt !== '0) begin
         bad++; $display("FAIL single_pulse_width: got start=%b gnt=%b want 0/0", o_start, o_gnt);
      end
      total++;
      if (o_data !== 8'hA5) begin
         bad++; $display("FAIL single_data_hold: got %h want a5", o_data);
      end
      guard = 0;
      while (frame_open && guard < 100) begin
         tick();
         guard++;
      end
      total++;
      if (frame_open) begin
         bad++; $display("FAIL single_frame_end: frame still open after %0d cycles", guard);
      end
   endtask

   task automatic test_all_requesting();
      int order[5] = '{0, 1, 2, 3, 0};
      int n;
      bit prev;
      logic [NREQ-1:0] want;
      logic [BW-1:0]   want_b;
      do_reset();
      auto_tx   = 1'b1;
      frame_len = 160;
      rand_data();
      req_i = 4'b1111;
      n     = 0;
      prev  = 1'b0;
      for (int t = 0; t < 1200 && n < 5; t++) begin
         tick();
         if (prev) begin
            total++;
            if (o_start !== 1'b0 || o_gnt !== '0) begin
               bad++; $display("FAIL all_pulse_width: got start=%b gnt=%b want 0/0", o_start, o_gnt);
            end
         end
         if (o_start) begin
            want         = '0;
            want[order[n]] = 1'b1;
            want_b       = sel_data[order[n]*BW +: BW];
            total++;
            if (o_gnt !== want) begin
               bad++; $display("FAIL all_order[%0d]: got %b want %b", n, o_gnt, want);
            end
            total++;
            if (o_data !== want_b) begin
               bad++; $display("FAIL all_data[%0d]: got %h want %h", n, o_data, want_b);
            end
            n++;
         end
         prev = o_start;
      end
      total++;
      if (n != 5) begin
         bad++; $display("FAIL all_grant_count: got %0d want 5", n);
      end
   endtask

   task automatic test_busy();
      int starts;
      do_reset();
      rand_data();
      tx_busy_i = 1'b1;
      req_i     = 4'b0100;
      starts    = 0;
      repeat (8) begin
         tick();
         if (o_start) starts++;
      end
      total++;
      if (starts != 0) begin
         bad++; $display("FAIL busy_hold: got %0d starts want 0", starts);
      end
      tx_busy_i = 1'b0;
      tick();
      total++;
      if (o_start !== 1'b1 || o_gnt !== 4'b0100) begin
         bad++; $display("FAIL busy_release: got start=%b gnt=%b want 1/0100", o_start, o_gnt);
      end
      total++;
      if (o_owner !== 2'd2) begin
         bad++; $display("FAIL busy_owner: got %0d want 2", o_owner);
      end
      req_i     = '0;
      tx_busy_i = 1'b1;
      repeat (3) tick();
      tx_busy_i = 1'b0;
      tx_done_i = 1'b1;
      tick();
      // pointer now rests on 2, so with everyone asking requester 3 is next
      req_i = 4'b1111;
      tick();
      total++;
      if (o_start !== 1'b1 || o_gnt !== 4'b1000) begin
         bad++; $display("FAIL busy_rotate: got start=%b gnt=%b want 1/1000", o_start, o_gnt);
      end
   endtask

   task automatic test_withdrawn();
      int gnts, bad_data, guard;
      logic [BW-1:0] b;
      do_reset();
      auto_tx   = 1'b1;
      frame_len = 12;
      rand_data();
      b = data_in_i[3*BW +: BW];
      req_i = 4'b1000;
      tick();
      req_i = '0;
      data_in_i = ~data_in_i;
      gnts     = (o_gnt != 0) ? 1 : 0;
      bad_data = 0;
      guard    = 0;
      while (frame_open && guard < 100) begin
         tick();
         if (o_gnt != 0) gnts++;
         if (frame_open && o_data !== b) bad_data++;
         guard++;
      end
      total++;
      if (gnts != 1) begin
         bad++; $display("FAIL withdrawn_gnt_count: got %0d want 1", gnts);
      end
      total++;
      if (bad_data != 0) begin
         bad++; $display("FAIL withdrawn_data_stable: got %0d bad cycles want 0", bad_data);
      end
      total++;
      if (o_owner !== 2'd3) begin
         bad++; $display("FAIL withdrawn_owner: got %0d want 3", o_owner);
      end
      total++;
      if (frame_open) begin
         bad++; $display("FAIL withdrawn_frame_end: frame open after %0d cycles", guard);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      auto_tx   = 1'b1;
      frame_len = 50;
      rand_data();
      data_in_i[1*BW +: BW] = data_in_i[1*BW +: BW] | 8'h01;
      req_i = 4'b0010;
      tick();
      req_i = '0;
      repeat (5) tick();
      #2 nreset = 1'b0;
      #1;
      total++;
      if (tx_start_o !== 1'b0 || gnt_o !== '0) begin
         bad++; $display("FAIL midreset_pulses: got start=%b gnt=%b want 0/0", tx_start_o, gnt_o);
      end
      total++;
      if (tx_data_o !== '0) begin
         bad++; $display("FAIL midreset_data: got %h want 0", tx_data_o);
      end
      total++;
      if (owner_o !== '0) begin
         bad++; $display("FAIL midreset_owner: got %0d want 0", owner_o);
      end
      tx_busy_i  = 1'b0;
      tx_done_i  = 1'b0;
      frame_open = 1'b0;
      last       = NREQ - 1;
      @(posedge clock_out);
      #1 nreset = 1'b1;
      req_i = 4'b1111;
      tick();
      total++;
      if (o_start !== 1'b1 || o_gnt !== 4'b0001 || o_owner !== 2'd0) begin
         bad++; $display("FAIL midreset_first_winner: got start=%b gnt=%b owner=%0d want 1/0001/0",
                         o_start, o_gnt, o_owner);
      end
      req_i = '0;
      guard = 0;
      while (frame_open && guard < 100) begin
         tick();
         guard++;
      end
   endtask

   task automatic test_random();
      logic exp_start;
      logic [BW-1:0] want_b;
      int grants;
      do_reset();
      auto_tx = 1'b1;
      grants  = 0;
      req_i   = NREQ'($urandom);
      rand_data();
      exp_start = (req_i != 0);
      for (int n = 0; n < 800; n++) begin
         frame_len = $urandom_range(1, 10);
         tick();
         total++;
         if (o_start !== exp_start) begin
            bad++; $display("FAIL rand_start[%0d]: got %b want %b", n, o_start, exp_start);
         end
         if (o_start) begin
            grants++;
            total++;
            if (exp_win < 0 || o_gnt !== exp_gnt) begin
               bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", n, o_gnt, exp_gnt);
            end
            if (exp_win >= 0) begin
               want_b = sel_data[exp_win*BW +: BW];
               total++;
               if (o_data !== want_b || o_owner !== OW'(exp_win)) begin
                  bad++; $display("FAIL rand_data_owner[%0d]: got %h/%0d want %h/%0d",
                                  n, o_data, o_owner, want_b, exp_win);
               end
            end
            req_i = NREQ'($urandom);
            rand_data();
         end else if (!frame_open && req_i == 0 && $urandom_range(0, 3) == 0) begin
            req_i = NREQ'($urandom);
            rand_data();
         end
         exp_start = !frame_open && (req_i != 0) && !tx_busy_i && !tx_done_i;
      end
      total++;
      if (grants < 20) begin
         bad++; $display("FAIL rand_grant_count: got %0d want at least 20", grants);
      end
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      rand_data();
      req_i = 4'b0001;
      tick();
      total++;
      if (o_start !== 1'b1) begin
         bad++; $display("FAIL tmo_launch: got %b want 1", o_start);
      end
      req_i = '0;
      for (int k = 1; k <= TMO; k++) begin
         tick();
         if (k == TMO - 1) begin
            total++;
            if (timeout_err_o !== 1'b0) begin
               bad++; $display("FAIL tmo_early: got %b want 0 at cycle %0d", timeout_err_o, k);
            end
         end
      end
      total++;
      if (timeout_err_o !== 1'b1) begin
         bad++; $display("FAIL tmo_flag: got %b want 1 at cycle %0d", timeout_err_o, TMO);
      end
      frame_open = 1'b0;
      last       = 0;
      req_i      = 4'b1111;
      tick();
      total++;
      if (o_start !== 1'b1 || o_gnt !== 4'b0010) begin
         bad++; $display("FAIL tmo_next_owner: got start=%b gnt=%b want 1/0010", o_start, o_gnt);
      end
      req_i = '0;
      repeat (3) tick();
      total++;
      if (timeout_err_o !== 1'b1) begin
         bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err_o);
      end
   endtask

   task automatic test_timeout_race();
      do_reset();
      rand_data();
      req_i = 4'b0001;
      tick();
      req_i = '0;
      for (int k = 1; k < TMO; k++) tick();
      tx_done_i = 1'b1;
      tick();
      total++;
      if (timeout_err_o !== 1'b0) begin
         bad++; $display("FAIL tmo_race_flag: got %b want 0", timeout_err_o);
      end
      req_i = 4'b0011;
      tick();
      total++;
      if (o_start !== 1'b1 || o_gnt !== 4'b0010) begin
         bad++; $display("FAIL tmo_race_next: got start=%b gnt=%b want 1/0010", o_start, o_gnt);
      end
      total++;
      if (timeout_err_o !== 1'b0) begin
         bad++; $display("FAIL tmo_race_hold: got %b want 0", timeout_err_o);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single();
      test_all_requesting();
      test_busy();
      test_withdrawn();
      test_reset_mid();
      test_random();
`ifdef UART_ARB_TIMEOUT_EN
      test_timeout();
      test_timeout_race();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
